// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_feeder
// Captures one raster-order frame, then replays every interior 3x3 window
// as a 9-byte serial burst followed by GAP idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int GAP   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int c_depth = IMG_W * IMG_H;
  localparam int c_aw    = $clog2(c_depth);
  localparam int c_cw    = $clog2(IMG_W);
  localparam int c_rw    = $clog2(IMG_H);
  localparam int c_gw    = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [c_depth];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_base;
  logic [c_aw-1:0] r_tap;
  logic [c_cw-1:0] r_col;
  logic [c_rw-1:0] r_row;
  logic [1:0]      r_kc;
  logic [1:0]      r_kr;
  logic [c_gw-1:0] r_gcnt;

  logic            w_wr;
  logic            w_rd;
  logic            w_last_win;
  logic [c_aw-1:0] w_next_base;
  logic [c_gw-1:0] w_gap_end;

  assign w_wr        = i_valid & o_ready;
  assign w_rd        = (r_state == S_STREAM);
  assign w_last_win  = (r_row == c_rw'(IMG_H - 3)) && (r_col == c_cw'(IMG_W - 3));
  // End of a row of windows jumps the origin to column 0 of the next row.
  assign w_next_base = (r_col == c_cw'(IMG_W - 3)) ? r_base + c_aw'(3) : r_base + c_aw'(1);
  // The final window holds one extra cycle so its idle run at the output is a full GAP.
  assign w_gap_end   = w_last_win ? c_gw'(GAP) : c_gw'(GAP - 1);

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_rst) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= 8'd0;
    end else begin
      o_valid <= w_rd;
      o_data  <= w_rd ? r_mem[r_tap] : 8'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      r_wptr  <= '0;
      r_base  <= '0;
      r_tap   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_kc    <= '0;
      r_kr    <= '0;
      r_gcnt  <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_valid && !o_ready) begin
        o_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_base <= '0;
          r_tap  <= '0;
          r_row  <= '0;
          r_col  <= '0;
          r_kc   <= '0;
          r_kr   <= '0;
          if (i_valid) begin
            r_wptr  <= c_aw'(1);
            r_state <= S_LOAD;
          end else begin
            r_wptr <= '0;
          end
        end
        S_LOAD: begin
          if (i_valid) begin
            if (r_wptr == c_aw'(c_depth - 1)) begin
              r_state <= S_STREAM;
              o_ready <= 1'b0;
              o_busy  <= 1'b1;
              r_wptr  <= '0;
            end else begin
              r_wptr <= r_wptr + c_aw'(1);
            end
          end
        end
        S_STREAM: begin
          if (r_kc == 2'd2) begin
            r_kc <= '0;
            if (r_kr == 2'd2) begin
              r_kr    <= '0;
              r_gcnt  <= '0;
              r_state <= S_GAP;
            end else begin
              r_kr  <= r_kr + 2'd1;
              r_tap <= r_tap + c_aw'(IMG_W - 2);
            end
          end else begin
            r_kc  <= r_kc + 2'd1;
            r_tap <= r_tap + c_aw'(1);
          end
        end
        S_GAP: begin
          if (r_gcnt == w_gap_end) begin
            if (w_last_win) begin
              r_state <= S_IDLE;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              r_state <= S_STREAM;
              r_base  <= w_next_base;
              r_tap   <= w_next_base;
              if (r_col == c_cw'(IMG_W - 3)) begin
                r_col <= '0;
                r_row <= r_row + c_rw'(1);
              end else begin
                r_col <= r_col + c_cw'(1);
              end
            end
          end else begin
            r_gcnt <= r_gcnt + c_gw'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
